snake_body: RTL and testbench

- Upstream stage of the apple generator. Holds the snake's segment coordinates on the 16x16 grid and advances the snake one cell per game step.
- Detects three events on each step: apple eaten (good collision), wall hit and self hit (bad collision).
- Drives the `body` array and the `goodColl` pulse that the apple generator consumes.

---
 rtl/snake_body.sv | 152 +++++++++++++++
 tb/tb_snake_body.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// Snake segment store and stepper on a 16x16 grid.
// Moves the head, detects apple/wall/self events, feeds the apple generator.
module snake_body #(
   parameter int MAX_LEN  = 50,
   parameter int INIT_LEN = 3,
   parameter int LEN_W    = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    move_tick,
   input  logic                    dir_valid,
   input  logic [1:0]              dir_req,
   input  logic [7:0]              apple_cord,
   output logic [MAX_LEN-1:0][7:0] body,
   output logic [LEN_W-1:0]        length,
   output logic                    goodColl,
   output logic                    badColl,
   output logic                    running
);

   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   localparam logic [1:0] UP    = 2'd0;
   localparam logic [1:0] RIGHT = 2'd1;
   localparam logic [1:0] DOWN  = 2'd2;
   localparam logic [1:0] LEFT  = 2'd3;

   localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);
   localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] INIT_L = LEN_W'(INIT_LEN);

   state_t                  state, state_nx;
   logic [1:0]              cur_dir, pend_dir;
   logic [1:0]              cur_nx, pend_nx;
   logic [MAX_LEN-1:0][7:0] body_nx, shifted, init_body;
   logic [LEN_W-1:0]        len_nx;
   logic                    good_nx;
   logic [3:0]              hx, hy;
   logic [7:0]              nh, new_tail;
   logic                    wall, self_hit, eat;

   // Start layout: horizontal snake on row 5, head at the right end.
   always_comb begin
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < INIT_LEN)
            init_body[i] = {4'(INIT_LEN + 1 - i), 4'd5};
         else
            init_body[i] = {4'd2, 4'd5};
      end
   end

   always_comb begin
      hx   = body[0][7:4];
      hy   = body[0][3:0];
      nh   = body[0];
      wall = 1'b0;
      unique case (pend_dir)
         UP: begin
            wall     = (hy == 4'd0);
            nh[3:0]  = hy - 4'd1;
         end
         RIGHT: begin
            wall     = (hx == 4'd15);
            nh[7:4]  = hx + 4'd1;
         end
         DOWN: begin
            wall     = (hy == 4'd15);
            nh[3:0]  = hy + 4'd1;
         end
         LEFT: begin
            wall     = (hx == 4'd0);
            nh[7:4]  = hx - 4'd1;
         end
      endcase
      eat = (nh == apple_cord);
      // The tail cell is free to enter unless eating keeps it occupied.
      self_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (((LEN_W'(i) < length - ONE) || (eat && LEN_W'(i) < length))
             && body[i] == nh)
            self_hit = 1'b1;
      end
      shifted[0] = nh;
      for (int i = 1; i < MAX_LEN; i++)
         shifted[i] = body[i-1];
      new_tail = shifted[length - ONE];
   end

   always_comb begin
      state_nx = state;
      body_nx  = body;
      len_nx   = length;
      cur_nx   = cur_dir;
      pend_nx  = pend_dir;
      good_nx  = 1'b0;
      if (dir_valid && dir_req != (cur_dir ^ 2'b10))
         pend_nx = dir_req;
      if (start) begin
         state_nx = RUN;
         body_nx  = init_body;
         len_nx   = INIT_L;
         cur_nx   = RIGHT;
         pend_nx  = RIGHT;
      end else begin
         unique case (state)
            RUN: begin
               if (move_tick) begin
                  if (wall || self_hit) begin
                     state_nx = DEAD;
                  end else begin
                     cur_nx  = pend_dir;
                     body_nx = shifted;
                     if (eat) begin
                        good_nx = 1'b1;
                        if (length < MAX_L)
                           len_nx = length + ONE;
                     end else begin
                        for (int i = 0; i < MAX_LEN; i++)
                           if (LEN_W'(i) >= length)
                              body_nx[i] = new_tail;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         body     <= init_body;
         length   <= INIT_L;
         cur_dir  <= RIGHT;
         pend_dir <= RIGHT;
         goodColl <= 1'b0;
      end else begin
         state    <= state_nx;
         body     <= body_nx;
         length   <= len_nx;
         cur_dir  <= cur_nx;
         pend_dir <= pend_nx;
         goodColl <= good_nx;
      end
   end

   assign badColl = (state == DEAD);
   assign running = (state == RUN);

endmodule

// File: tb/tb_snake_body.sv
// Directed self-checking bench for snake_body.
// Each task drives one scenario and checks against hand-worked values.
module tb_snake_body;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             move_tick = 1'b0;
   logic             dir_valid = 1'b0;
   logic [1:0]       dir_req = 2'd0;
   logic [7:0]       apple_cord = 8'h00;
   logic [49:0][7:0] body;
   logic [5:0]       length;
   logic             goodColl;
   logic             badColl;
   logic             running;

   int checks = 0;
   int failures = 0;
   int hx, hy;

   localparam logic [1:0] UP    = 2'd0;
   localparam logic [1:0] RIGHT = 2'd1;
   localparam logic [1:0] DOWN  = 2'd2;
   localparam logic [1:0] LEFT  = 2'd3;

   snake_body dut (
      .clk(clk), .reset(reset), .start(start), .move_tick(move_tick),
      .dir_valid(dir_valid), .dir_req(dir_req), .apple_cord(apple_cord),
      .body(body), .length(length), .goodColl(goodColl),
      .badColl(badColl), .running(running)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk) move_tick = 1'b1;
      @(negedge clk) move_tick = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic set_dir(input logic [1:0] d);
      @(negedge clk) begin dir_valid = 1'b1; dir_req = d; end
      @(negedge clk) dir_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++; if (body[0] !== 8'h45) begin failures++;
         $display("FAIL rst_head got=%h exp=45", body[0]); end
      checks++; if (body[1] !== 8'h35 || body[2] !== 8'h25) begin failures++;
         $display("FAIL rst_body got=%h,%h exp=35,25", body[1], body[2]); end
      checks++; if (body[49] !== 8'h25) begin failures++;
         $display("FAIL rst_unused got=%h exp=25", body[49]); end
      checks++; if ({length, goodColl, badColl, running} !== {6'd3, 3'b000}) begin
         failures++;
         $display("FAIL rst_flags got=%0d %b%b%b exp=3 000",
                  length, goodColl, badColl, running); end
      tick();
      checks++; if (body[0] !== 8'h45 || running !== 1'b0) begin failures++;
         $display("FAIL idle_tick got=%h run=%b exp=45 run=0", body[0], running); end
   endtask

   task automatic test_move();
      logic seen_good = 1'b0;
      logic ok = 1'b1;
      apple_cord = 8'hC5;
      pulse_start();
      checks++; if (running !== 1'b1) begin failures++;
         $display("FAIL start_run got=%b exp=1", running); end
      repeat (3) begin
         tick();
         if (goodColl) seen_good = 1'b1;
      end
      checks++; if (body[0] !== 8'h75 || body[1] !== 8'h65 || body[2] !== 8'h55)
      begin failures++;
         $display("FAIL move3 got=%h,%h,%h exp=75,65,55", body[0], body[1], body[2]); end
      for (int i = 3; i < 50; i++) if (body[i] !== 8'h55) ok = 1'b0;
      checks++; if (!ok || length !== 6'd3) begin failures++;
         $display("FAIL move_tail got=%h len=%0d exp=55 len=3", body[49], length); end
      checks++; if (seen_good !== 1'b0) begin failures++;
         $display("FAIL move_good got=%b exp=0", seen_good); end
   endtask

   task automatic test_eat();
      apple_cord = 8'h55;
      pulse_start();
      tick();
      checks++; if (goodColl !== 1'b1) begin failures++;
         $display("FAIL eat_pulse got=%b exp=1", goodColl); end
      checks++; if (body[0] !== 8'h55 || length !== 6'd4 || body[3] !== 8'h25)
      begin failures++;
         $display("FAIL eat_body got=%h len=%0d b3=%h exp=55 4 25",
                  body[0], length, body[3]); end
      checks++; if (body[49] !== 8'h25) begin failures++;
         $display("FAIL eat_unused got=%h exp=25", body[49]); end
      @(negedge clk);
      checks++; if (goodColl !== 1'b0) begin failures++;
         $display("FAIL eat_pulse_end got=%b exp=0", goodColl); end
   endtask

   task automatic test_dir();
      apple_cord = 8'hFF;
      pulse_start();
      set_dir(LEFT);
      tick();
      checks++; if (body[0] !== 8'h55) begin failures++;
         $display("FAIL dir_reverse got=%h exp=55", body[0]); end
      set_dir(UP);
      tick();
      checks++; if (body[0] !== 8'h54) begin failures++;
         $display("FAIL dir_up got=%h exp=54", body[0]); end
      set_dir(LEFT);
      set_dir(RIGHT);
      tick();
      checks++; if (body[0] !== 8'h64) begin failures++;
         $display("FAIL dir_last got=%h exp=64", body[0]); end
      @(negedge clk) begin move_tick = 1'b1; dir_valid = 1'b1; dir_req = DOWN; end
      @(negedge clk) begin move_tick = 1'b0; dir_valid = 1'b0; end
      checks++; if (body[0] !== 8'h74) begin failures++;
         $display("FAIL dir_same_cycle got=%h exp=74", body[0]); end
      tick();
      checks++; if (body[0] !== 8'h75) begin failures++;
         $display("FAIL dir_applied got=%h exp=75", body[0]); end
   endtask

   task automatic test_wall();
      apple_cord = 8'h00;
      pulse_start();
      repeat (11) tick();
      checks++; if (body[0] !== 8'hF5 || running !== 1'b1) begin failures++;
         $display("FAIL wall_edge got=%h run=%b exp=F5 1", body[0], running); end
      tick();
      checks++; if (badColl !== 1'b1 || running !== 1'b0) begin failures++;
         $display("FAIL wall_dead got=%b%b exp=10", badColl, running); end
      checks++; if (body[0] !== 8'hF5 || body[1] !== 8'hE5 || length !== 6'd3)
      begin failures++;
         $display("FAIL wall_frozen got=%h,%h len=%0d exp=F5,E5 3",
                  body[0], body[1], length); end
      set_dir(UP);
      tick();
      checks++; if (body[0] !== 8'hF5 || badColl !== 1'b1) begin failures++;
         $display("FAIL dead_tick got=%h bad=%b exp=F5 1", body[0], badColl); end
      pulse_start();
      checks++; if (body[0] !== 8'h45 || running !== 1'b1 || badColl !== 1'b0)
      begin failures++;
         $display("FAIL restart got=%h run=%b bad=%b exp=45 1 0",
                  body[0], running, badColl); end
   endtask

   task automatic test_self();
      apple_cord = 8'h55;
      pulse_start();
      tick();
      apple_cord = 8'h65;
      tick();
      apple_cord = 8'h00;
      set_dir(UP);    tick();
      set_dir(LEFT);  tick();
      set_dir(DOWN);  tick();
      checks++; if (badColl !== 1'b1 || body[0] !== 8'h54 || length !== 6'd5)
      begin failures++;
         $display("FAIL self_hit got=%b %h len=%0d exp=1 54 5",
                  badColl, body[0], length); end
      apple_cord = 8'h55;
      pulse_start();
      tick();
      apple_cord = 8'h00;
      set_dir(UP);    tick();
      set_dir(LEFT);  tick();
      set_dir(DOWN);  tick();
      checks++; if (badColl !== 1'b0 || body[0] !== 8'h45 || body[3] !== 8'h55)
      begin failures++;
         $display("FAIL tail_chase got=%b %h %h exp=0 45 55",
                  badColl, body[0], body[3]); end
      checks++; if (body[49] !== 8'h55 || length !== 6'd4) begin failures++;
         $display("FAIL tail_chase_unused got=%h len=%0d exp=55 4",
                  body[49], length); end
      apple_cord = 8'h55;
      pulse_start();
      tick();
      apple_cord = 8'h45;
      set_dir(UP);    tick();
      set_dir(LEFT);  tick();
      set_dir(DOWN);  tick();
      checks++; if (badColl !== 1'b1 || goodColl !== 1'b0) begin failures++;
         $display("FAIL eat_tail got=%b good=%b exp=1 0", badColl, goodColl); end
   endtask

   task automatic seg(input logic [1:0] d, input int n);
      set_dir(d);
      repeat (n) begin
         unique case (d)
            UP:    hy = hy - 1;
            RIGHT: hx = hx + 1;
            DOWN:  hy = hy + 1;
            LEFT:  hx = hx - 1;
         endcase
         apple_cord = {4'(hx), 4'(hy)};
         tick();
      end
   endtask

   task automatic test_max_len();
      hx = 4; hy = 5;
      pulse_start();
      seg(RIGHT, 11); seg(DOWN, 1); seg(LEFT, 15); seg(DOWN, 1);
      seg(RIGHT, 15); seg(DOWN, 1); seg(LEFT, 3);
      checks++; if (length !== 6'd50 || body[0] !== 8'hC8) begin failures++;
         $display("FAIL grow_max got=%0d %h exp=50 C8", length, body[0]); end
      seg(LEFT, 1);
      checks++; if (length !== 6'd50 || goodColl !== 1'b1 || badColl !== 1'b0)
      begin failures++;
         $display("FAIL max_eat got=%0d good=%b bad=%b exp=50 1 0",
                  length, goodColl, badColl); end
      checks++; if (body[0] !== 8'hB8 || body[49] !== 8'h35) begin failures++;
         $display("FAIL max_shift got=%h %h exp=B8 35", body[0], body[49]); end
   endtask

   task automatic test_start_tick();
      @(negedge clk) begin start = 1'b1; move_tick = 1'b1; end
      @(negedge clk) begin start = 1'b0; move_tick = 1'b0; end
      checks++; if (body[0] !== 8'h45 || length !== 6'd3 || body[49] !== 8'h25)
      begin failures++;
         $display("FAIL start_tick got=%h len=%0d %h exp=45 3 25",
                  body[0], length, body[49]); end
      checks++; if (running !== 1'b1 || goodColl !== 1'b0) begin failures++;
         $display("FAIL start_tick_flags got=%b %b exp=1 0", running, goodColl); end
   endtask

   initial begin
      test_reset();
      test_move();
      test_eat();
      test_dir();
      test_wall();
      test_self();
      test_max_len();
      test_start_tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
